// File: rtl/idex_fwd_reg_pkg.sv
// Shared constants for the ID/EX register and the operand muxes.
// Select encoding must match the bit32_mux3to1 input order.
package idex_fwd_reg_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/idex_fwd_reg_fwd_sel.sv
// Forwarding select for one ALU operand.
// MEM beats WB; register 0 is never forwarded.
module fwd_sel
    import idex_fwd_reg_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] idx,
    input  logic          ex_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_reg_write,
    output logic [1:0]    sel
);

    logic mem_hit;
    logic wb_hit;
    logic wb_only;

    assign mem_hit = ex_valid && mem_reg_write &&
                     (mem_rd != '0) && (mem_rd == idx);
    assign wb_hit  = ex_valid && wb_reg_write &&
                     (wb_rd != '0) && (wb_rd == idx);
    assign wb_only = wb_hit && !mem_hit;

    // Pick the newest in-flight producer of the operand.
    always_comb begin
        sel = FWD_REG;
        unique case (1'b1)
            mem_hit: sel = FWD_MEM;
            wb_only: sel = FWD_WB;
            default: sel = FWD_REG;
        endcase
    end

endmodule

// File: rtl/idex_fwd_reg.sv
// ID/EX pipeline register with stall/flush and
// forwarding selects for the two ALU operand muxes.
module idex_fwd_reg
    import idex_fwd_reg_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs1_data,
    input  logic [DW-1:0] id_rs2_data,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic [AW-1:0] id_rd,
    input  logic          id_reg_write,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_reg_write,
    output logic          ex_valid,
    output logic [DW-1:0] ex_rs1_data,
    output logic [DW-1:0] ex_rs2_data,
    output logic [AW-1:0] ex_rs1,
    output logic [AW-1:0] ex_rs2,
    output logic [AW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic [1:0]    fwd_a_sel,
    output logic [1:0]    fwd_b_sel
);

    // Flush wins over stall; a bubble never writes back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= id_valid;
            ex_rs1_data  <= id_rs1_data;
            ex_rs2_data  <= id_rs2_data;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_reg_write <= id_valid & id_reg_write;
        end
    end

    fwd_sel #(.AW(AW)) u_fwd_a (
        .idx           (ex_rs1),
        .ex_valid      (ex_valid),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_a_sel)
    );

    fwd_sel #(.AW(AW)) u_fwd_b (
        .idx           (ex_rs2),
        .ex_valid      (ex_valid),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_b_sel)
    );

endmodule

// File: doc/idex_fwd_reg.md
Name: idex_fwd_reg

Overview:
- ID/EX pipeline register for the 32-bit datapath. Directly upstream of the ALU-operand 3:1 muxes (bit32_mux3to1).
- Latches decoded operands and register indices from ID once per cycle, with stall and flush.
- Generates the 2-bit select for each operand mux so that results still in MEM/WB are forwarded.
- Mux input mapping: in1 = register-file operand from this block, in2 = MEM-stage result, in3 = WB-stage result.

Parameters:
- DATA_W, 32, operand data width
- REG_AW, 5, register-index width (32 architectural registers; index 0 is hard-wired zero)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold all registered outputs this cycle
- flush  input  1  replace the incoming instruction with a bubble
- id_valid  input  1  ID stage holds a real instruction
- id_rs1_data  input  DATA_W  rs1 value read in ID
- id_rs2_data  input  DATA_W  rs2 value read in ID
- id_rs1  input  REG_AW  rs1 index
- id_rs2  input  REG_AW  rs2 index
- id_rd  input  REG_AW  destination index
- id_reg_write  input  1  instruction writes rd
- mem_rd  input  REG_AW  MEM-stage destination index
- mem_reg_write  input  1  MEM-stage instruction writes rd
- wb_rd  input  REG_AW  WB-stage destination index
- wb_reg_write  input  1  WB-stage instruction writes rd
- ex_valid  output  1  EX holds a real instruction
- ex_rs1_data  output  DATA_W  registered rs1 value; drives mux A in1
- ex_rs2_data  output  DATA_W  registered rs2 value; drives mux B in1
- ex_rs1  output  REG_AW  registered rs1 index
- ex_rs2  output  REG_AW  registered rs2 index
- ex_rd  output  REG_AW  registered destination index
- ex_reg_write  output  1  registered write enable
- fwd_a_sel  output  2  select for operand-A mux
- fwd_b_sel  output  2  select for operand-B mux

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous and active-high on port reset.
- Reset: all registered outputs go to 0 immediately, independent of clk. Consequently fwd_a_sel = fwd_b_sel = 0. Reset asserted mid-operation discards the in-flight instruction. The first edge after deassertion loads normally.
- Update priority at each rising clk edge: reset > flush > stall > load.
  - flush = 1: ex_valid = 0, ex_reg_write = 0, ex_rd = ex_rs1 = ex_rs2 = 0, data fields = 0. This applies even when stall = 1 in the same cycle.
  - stall = 1, flush = 0: every registered output holds its value.
  - Otherwise: all ex_* fields take the id_* values. ex_valid takes id_valid.
- id_valid = 0 load: ex_reg_write is forced to 0 regardless of id_reg_write.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs.
- Forwarding select logic:
  - Combinational from the registered ex_* fields and the live mem_*/wb_* inputs. Same-cycle response, no register.
  - Encoding: 0 = FWD_REG, 1 = FWD_MEM, 2 = FWD_WB. The value 3 is never driven.
  - Per operand X in {rs1 -> fwd_a_sel, rs2 -> fwd_b_sel}:
    - ex_valid = 0 -> 0.
    - Else if mem_reg_write and mem_rd != 0 and mem_rd == ex_X -> 1.
    - Else if wb_reg_write and wb_rd != 0 and wb_rd == ex_X -> 2.
    - Else -> 0.
  - MEM has priority over WB when both match, because MEM holds the newer value.
  - Index 0 is never forwarded, even when a writer targets it.
  - rs1 == rs2 is legal: both selects compute independently and may be equal.
- During stall, the selects still track changing mem_*/wb_* inputs. The EX instruction keeps picking up the newest producer.
- No arithmetic is performed; data passes through unmodified at DATA_W bits.

Decomposition:
- Shared include/package: FWD_REG = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2, plus REG_AW and DATA_W defaults. The mux stage uses the same constants.
- One natural sub-module: fwd_sel. It takes an index, ex_valid and the mem/wb pairs, and produces a 2-bit select. It is instantiated twice (operand A and operand B).

Test Plan:
- Reset: assert reset mid-cycle with ex_valid = 1 and ex_rd = 7 -> all outputs 0 before the next edge; selects = 0.
- Load and no forward: id_rs1 = 3, id_rs1_data = 76, id_rs2 = 4, id_rs2_data = 90, mem_rd = wb_rd = 9 -> after 1 edge, ex_rs1_data = 76, ex_rs2_data = 90, fwd_a_sel = fwd_b_sel = 0.
- Forward priority: ex_rs1 = 5, ex_rs2 = 5, mem_rd = 5 with mem_reg_write = 1, wb_rd = 5 with wb_reg_write = 1 -> fwd_a_sel = fwd_b_sel = 1. Drop mem_reg_write -> both = 2.
- Zero register: ex_rs1 = 0, mem_rd = 0 with mem_reg_write = 1 -> fwd_a_sel = 0.
- Stall/flush: stall = 1 with new id data 555 -> ex_rs1_data holds 76. stall = 1 and flush = 1 together -> ex_valid = 0, ex_reg_write = 0, selects = 0 next cycle.
- Bubble input: id_valid = 0 with id_reg_write = 1 -> ex_reg_write = 0 after the edge.
